hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage (F→D→E→M→W) MIPS core. Watches register sources in D and E against destinations in E/M/W. Produces stall, flush and forwarding selects for the datapath, and schedules the shared multi-cycle multiply/divide unit with a busy counter. It sits beside the main controller, and its `DE_clr` output drives the D/E control and data pipeline registers.

---
 rtl/hazard_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage MIPS pipeline: stall/flush generation,
// D and E stage forwarding selects, and multiply/divide unit busy tracking.
module hazard_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] tuse_rs_D,
   input  logic [1:0] tuse_rt_D,
   input  logic [4:0] rs_E,
   input  logic [4:0] rt_E,
   input  logic [4:0] wa_E,
   input  logic [4:0] wa_M,
   input  logic [4:0] wa_W,
   input  logic       RegWrite_E,
   input  logic       RegWrite_M,
   input  logic       RegWrite_W,
   input  logic [1:0] GRF_WDSrc_E,
   input  logic [1:0] GRF_WDSrc_M,
   input  logic       md_start_E,
   input  logic       md_div_E,
   input  logic       md_use_D,
   output logic       stall_F,
   output logic       stall_D,
   output logic       DE_clr,
   output logic [1:0] FwdA_D,
   output logic [1:0] FwdB_D,
   output logic [1:0] FwdA_E,
   output logic [1:0] FwdB_E,
   output logic       md_busy
);

   localparam logic [1:0] WD_MEM   = 2'b01;
   localparam logic [1:0] TUSE_D   = 2'd0;
   localparam logic [1:0] TUSE_E   = 2'd1;
   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_M    = 2'd1;
   localparam logic [1:0] FWD_W    = 2'd2;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [3:0] md_cnt_q;
   logic [3:0] md_cnt_d;

   function automatic logic match(input logic we, input logic [4:0] wa, input logic [4:0] r);
      return we && (wa == r) && (r != 5'd0);
   endfunction

   // Stall contribution of one D-stage source operand.
   function automatic logic operand_stall(
      input logic [4:0] r,
      input logic [1:0] tuse,
      input logic       rw_e,
      input logic [4:0] wa_e,
      input logic [1:0] wd_e,
      input logic       rw_m,
      input logic [4:0] wa_m,
      input logic [1:0] wd_m
   );
      logic hit_e;
      logic hit_m;
      hit_e = match(rw_e, wa_e, r);
      hit_m = match(rw_m, wa_m, r);
      return (hit_e && (wd_e == WD_MEM) && (tuse <= TUSE_E))
          || (hit_e && (tuse == TUSE_D))
          || (hit_m && (wd_m == WD_MEM) && (tuse == TUSE_D));
   endfunction

   // A load sitting in M has no result yet, so it is never a forwarding source.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] r,
      input logic       rw_m,
      input logic [4:0] wa_m,
      input logic [1:0] wd_m,
      input logic       rw_w,
      input logic [4:0] wa_w
   );
      if (match(rw_m, wa_m, r) && (wd_m != WD_MEM)) begin
         return FWD_M;
      end
      if (match(rw_w, wa_w, r)) begin
         return FWD_W;
      end
      return FWD_NONE;
   endfunction

   logic stall_raw;
   logic busy_raw;

   assign busy_raw  = md_start_E || (md_cnt_q != 4'd0);
   assign stall_raw =
        operand_stall(rs_D, tuse_rs_D, RegWrite_E, wa_E, GRF_WDSrc_E, RegWrite_M, wa_M, GRF_WDSrc_M)
     || operand_stall(rt_D, tuse_rt_D, RegWrite_E, wa_E, GRF_WDSrc_E, RegWrite_M, wa_M, GRF_WDSrc_M)
     || (md_use_D && busy_raw);

   // NOTE: every output gets a default at the top of the block so no path
   // through it leaves a signal unassigned, which would infer a latch.
   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      DE_clr  = 1'b0;
      FwdA_D  = FWD_NONE;
      FwdB_D  = FWD_NONE;
      FwdA_E  = FWD_NONE;
      FwdB_E  = FWD_NONE;
      md_busy = 1'b0;
      if (reset) begin
         stall_F = stall_raw;
         stall_D = stall_raw;
         DE_clr  = stall_raw;
         FwdA_D  = fwd_sel(rs_D, RegWrite_M, wa_M, GRF_WDSrc_M, RegWrite_W, wa_W);
         FwdB_D  = fwd_sel(rt_D, RegWrite_M, wa_M, GRF_WDSrc_M, RegWrite_W, wa_W);
         FwdA_E  = fwd_sel(rs_E, RegWrite_M, wa_M, GRF_WDSrc_M, RegWrite_W, wa_W);
         FwdB_E  = fwd_sel(rt_E, RegWrite_M, wa_M, GRF_WDSrc_M, RegWrite_W, wa_W);
         md_busy = busy_raw;
      end
   end

   // A new md instruction always reloads, even over a nonzero count.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_start_E) begin
         md_cnt_d = md_div_E ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt_q != 4'd0) begin
         md_cnt_d = md_cnt_q - 4'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples its pre-edge inputs regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         md_cnt_q <= 4'd0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline scenarios plus
// randomized cycles compared against a rule-level reference model.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W;
   logic [1:0] tuse_rs_D, tuse_rt_D, GRF_WDSrc_E, GRF_WDSrc_M;
   logic       RegWrite_E, RegWrite_M, RegWrite_W;
   logic       md_start_E, md_div_E, md_use_D;
   logic       stall_F, stall_D, DE_clr, md_busy;
   logic [1:0] FwdA_D, FwdB_D, FwdA_E, FwdB_E;

   always #5 clk = ~clk;

   hazard_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .rs_E(rs_E), .rt_E(rt_E), .wa_E(wa_E), .wa_M(wa_M), .wa_W(wa_W),
      .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .GRF_WDSrc_E(GRF_WDSrc_E), .GRF_WDSrc_M(GRF_WDSrc_M),
      .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
      .stall_F(stall_F), .stall_D(stall_D), .DE_clr(DE_clr),
      .FwdA_D(FwdA_D), .FwdB_D(FwdB_D), .FwdA_E(FwdA_E), .FwdB_E(FwdB_E),
      .md_busy(md_busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference md model: cycle number of the last md start and its length.
   int cyc     = 0;
   int md_last = -1000;
   int md_n    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit hit(input bit we, input logic [4:0] wa, input logic [4:0] r);
      return we && (wa == r) && (r != 0);
   endfunction

   function automatic bit op_stall(input logic [4:0] r, input logic [1:0] tu);
      bit e, m;
      e = hit(RegWrite_E, wa_E, r);
      m = hit(RegWrite_M, wa_M, r);
      return (e && GRF_WDSrc_E == 2'b01 && tu <= 1) || (e && tu == 0)
          || (m && GRF_WDSrc_M == 2'b01 && tu == 0);
   endfunction

   function automatic int fwd(input logic [4:0] r);
      if (hit(RegWrite_M, wa_M, r) && GRF_WDSrc_M != 2'b01) return 1;
      if (hit(RegWrite_W, wa_W, r)) return 2;
      return 0;
   endfunction

   // Settle, then compare every output against the model.
   task automatic step(input string tag);
      bit busy_e, st_e;
      #1;
      busy_e = reset && (md_start_E || (cyc > md_last && cyc <= md_last + md_n));
      st_e   = reset && (op_stall(rs_D, tuse_rs_D) || op_stall(rt_D, tuse_rt_D)
                         || (md_use_D && busy_e));
      check({tag, ".stall_F"}, stall_F, st_e);
      check({tag, ".stall_D"}, stall_D, st_e);
      check({tag, ".DE_clr"},  DE_clr,  st_e);
      check({tag, ".FwdA_D"},  FwdA_D,  reset ? fwd(rs_D) : 0);
      check({tag, ".FwdB_D"},  FwdB_D,  reset ? fwd(rt_D) : 0);
      check({tag, ".FwdA_E"},  FwdA_E,  reset ? fwd(rs_E) : 0);
      check({tag, ".FwdB_E"},  FwdB_E,  reset ? fwd(rt_E) : 0);
      check({tag, ".md_busy"}, md_busy, busy_e);
   endtask

   // Clock edge: advance the model, then return to the falling edge for driving.
   task automatic adv();
      @(posedge clk);
      if (!reset) begin
         md_last = -1000;
      end else if (md_start_E) begin
         md_last = cyc;
         md_n    = md_div_E ? 10 : 5;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 1'b1;
      rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; wa_E = 0; wa_M = 0; wa_W = 0;
      tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; GRF_WDSrc_E = 0; GRF_WDSrc_M = 0;
      RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
      md_start_E = 0; md_div_E = 0; md_use_D = 0;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         step("rst");
         adv();
      end

      // Load-use: lw $8 in E, addu with rs=8 in D.
      idle(); wa_E = 8; RegWrite_E = 1; GRF_WDSrc_E = 2'b01; rs_D = 8; tuse_rs_D = 1;
      step("lu0"); check("lu0.stall", stall_F, 1); adv();
      idle(); wa_M = 8; RegWrite_M = 1; GRF_WDSrc_M = 2'b01; rs_D = 8; tuse_rs_D = 1;
      step("lu1"); check("lu1.stall", stall_F, 0); adv();
      idle(); wa_W = 8; RegWrite_W = 1; rs_E = 8;
      step("lu2"); check("lu2.FwdA_E", FwdA_E, 2); adv();

      // Branch after ALU op.
      idle(); wa_E = 9; RegWrite_E = 1; rt_D = 9; tuse_rt_D = 0;
      step("br0"); check("br0.stall", stall_D, 1); adv();
      idle(); wa_M = 9; RegWrite_M = 1; rt_D = 9; tuse_rt_D = 0;
      step("br1"); check("br1.stall", stall_D, 0); check("br1.FwdB_D", FwdB_D, 1); adv();
      // Branch after load: stalls in E and in M.
      idle(); wa_E = 9; RegWrite_E = 1; GRF_WDSrc_E = 2'b01; rt_D = 9; tuse_rt_D = 0;
      step("bl0"); check("bl0.stall", DE_clr, 1); adv();
      idle(); wa_M = 9; RegWrite_M = 1; GRF_WDSrc_M = 2'b01; rt_D = 9; tuse_rt_D = 0;
      step("bl1"); check("bl1.stall", DE_clr, 1); check("bl1.FwdB_D", FwdB_D, 0); adv();
      idle(); wa_W = 9; RegWrite_W = 1; rt_D = 9; tuse_rt_D = 0;
      step("bl2"); check("bl2.stall", DE_clr, 0); check("bl2.FwdB_D", FwdB_D, 2); adv();

      // M over W priority, then register $0.
      idle(); wa_M = 5; wa_W = 5; RegWrite_M = 1; RegWrite_W = 1; rs_E = 5;
      step("pri"); check("pri.FwdA_E", FwdA_E, 1); adv();
      idle(); RegWrite_E = 1; RegWrite_M = 1; RegWrite_W = 1; GRF_WDSrc_E = 2'b01;
      tuse_rs_D = 0; tuse_rt_D = 0;
      step("r0"); check("r0.stall", stall_F, 0); check("r0.FwdA_D", FwdA_D, 0); adv();

      // Store data: sw rt=4 (tuse 2) behind lw $4.
      idle(); wa_E = 4; RegWrite_E = 1; GRF_WDSrc_E = 2'b01; rt_D = 4; tuse_rt_D = 2;
      step("sw"); check("sw.stall", stall_F, 0); adv();

      // Multiply then mflo: stall cycles 0..5, issue at 6.
      for (int c = 0; c <= 6; c++) begin
         idle(); md_use_D = 1; md_start_E = (c == 0);
         step($sformatf("mul%0d", c));
         check($sformatf("mul%0d.stall", c), stall_F, c <= 5);
         check($sformatf("mul%0d.busy", c), md_busy, c <= 5);
         adv();
      end

      // Divide interrupted by reset at cycle 3, mfhi at cycle 4.
      for (int c = 0; c <= 4; c++) begin
         idle(); md_start_E = (c == 0); md_div_E = (c == 0);
         if (c == 3) begin
            reset = 0; md_use_D = 1; wa_E = 7; RegWrite_E = 1; rs_D = 7; tuse_rs_D = 0;
            wa_M = 7; RegWrite_M = 1;
         end
         if (c == 4) md_use_D = 1;
         step($sformatf("div%0d", c));
         check($sformatf("div%0d.busy", c), md_busy, c <= 2);
         if (c >= 3) check($sformatf("div%0d.stall", c), stall_F, 0);
         adv();
      end

      // Randomized cycles.
      for (int n = 0; n < 600; n++) begin
         idle();
         reset       = ($urandom_range(0, 29) != 0);
         rs_D        = 5'($urandom_range(0, 3));
         rt_D        = 5'($urandom_range(0, 3));
         rs_E        = 5'($urandom_range(0, 3));
         rt_E        = 5'($urandom_range(0, 3));
         wa_E        = 5'($urandom_range(0, 3));
         wa_M        = 5'($urandom_range(0, 3));
         wa_W        = 5'($urandom_range(0, 3));
         tuse_rs_D   = 2'($urandom_range(0, 3));
         tuse_rt_D   = 2'($urandom_range(0, 3));
         GRF_WDSrc_E = 2'($urandom_range(0, 3));
         GRF_WDSrc_M = 2'($urandom_range(0, 3));
         RegWrite_E  = 1'($urandom_range(0, 1));
         RegWrite_M  = 1'($urandom_range(0, 1));
         RegWrite_W  = 1'($urandom_range(0, 1));
         md_start_E  = ($urandom_range(0, 9) == 0);
         md_div_E    = 1'($urandom_range(0, 1));
         md_use_D    = ($urandom_range(0, 2) == 0);
         step("rnd");
         adv();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
